// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the ALU issue stage.
//   ALUfn encodings {subtract,bool1,bool0,shft,math}, the decoded-op record
//   and the occupancy encoding of the two-entry skid buffer.
package mips_pkg;

  localparam int ISS_N  = 32;
  localparam int ISS_RW = 5;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b10001;
  localparam logic [4:0] ALU_AND = 5'b01000;
  localparam logic [4:0] ALU_OR  = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00010;

  typedef struct packed {
    logic [ISS_RW-1:0] rs;
    logic [ISS_RW-1:0] rt;
    logic [ISS_N-1:0]  a;
    logic [ISS_N-1:0]  b;
    logic              b_imm;
    logic [4:0]        fn;
    logic [ISS_RW-1:0] rd;
    logic              we;
  } issue_op_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the current value of one source operand.
//   src        : source register of the operand
//   stored     : value held with the op
//   ex_*/wb_*  : producers in EX and WB (EX is younger, so it wins)
//   dis        : 1 = return stored untouched (immediate, or forwarding off)
//   value      : resolved operand
module fwd_mux #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [N-1:0]  stored,
  input  logic          ex_we,
  input  logic [RW-1:0] ex_rd,
  input  logic [N-1:0]  ex_result,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  input  logic          dis,
  output logic [N-1:0]  value
);

  always_comb begin
    value = stored;
    // register 0 is hardwired, so it never takes a forwarded value
    if (!dis && src != '0) begin
      if (ex_we && ex_rd == src)      value = ex_result;
      else if (wb_we && wb_rd == src) value = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: last stage before the ALU. Two-entry skid buffer
// (MAIN drives the ALU, SKID absorbs one op of backpressure) with EX/WB
// forwarding on A and B.
//   in_*      : decoded op from decode, valid/ready handshake
//   out_*     : op presented to the ALU, valid/ready handshake
//   ex_*/wb_* : producer snoop ports
//   flush     : synchronous discard of every held op
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int N   = 32,
  parameter int RW  = 5,
  parameter bit FWD = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_b_imm,
  input  logic [4:0]    in_fn,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_a,
  output logic [N-1:0]  out_b,
  output logic [4:0]    out_fn,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  input  logic          ex_we,
  input  logic [RW-1:0] ex_rd,
  input  logic [N-1:0]  ex_result,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_data
);

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          b_imm;
    logic [4:0]    fn;
    logic [RW-1:0] rd;
    logic          we;
  } op_t;

  occ_t state;
  op_t  main_q, skid_q, in_op, sel_op, main_fwd, sel_fwd;
  logic [N-1:0] main_fa, main_fb, sel_fa, sel_fb;
  logic acc, dq;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign acc = in_valid & in_ready;
  assign dq  = out_valid & out_ready;

  assign in_op = '{rs: in_rs, rt: in_rt, a: in_a, b: in_b, b_imm: in_b_imm,
                   fn: in_fn, rd: in_rd, we: in_we};

  // SKID is only valid when FULL, and nothing is captured when FULL, so one
  // mux pair serves both the SKID snoop and the incoming-op capture.
  assign sel_op = (state == FULL) ? skid_q : in_op;

  fwd_mux #(.N(N), .RW(RW)) u_main_a (
    .src(main_q.rs), .stored(main_q.a), .ex_we(ex_we), .ex_rd(ex_rd),
    .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dis(!FWD), .value(main_fa));

  fwd_mux #(.N(N), .RW(RW)) u_main_b (
    .src(main_q.rt), .stored(main_q.b), .ex_we(ex_we), .ex_rd(ex_rd),
    .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dis(!FWD || main_q.b_imm), .value(main_fb));

  fwd_mux #(.N(N), .RW(RW)) u_sel_a (
    .src(sel_op.rs), .stored(sel_op.a), .ex_we(ex_we), .ex_rd(ex_rd),
    .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dis(!FWD), .value(sel_fa));

  fwd_mux #(.N(N), .RW(RW)) u_sel_b (
    .src(sel_op.rt), .stored(sel_op.b), .ex_we(ex_we), .ex_rd(ex_rd),
    .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dis(!FWD || sel_op.b_imm), .value(sel_fb));

  always_comb begin
    main_fwd   = main_q;
    main_fwd.a = main_fa;
    main_fwd.b = main_fb;
    sel_fwd    = sel_op;
    sel_fwd.a  = sel_fa;
    sel_fwd.b  = sel_fb;
  end

  assign out_a  = main_fa;
  assign out_b  = main_fb;
  assign out_fn = main_q.fn;
  assign out_rd = main_q.rd;
  assign out_we = main_q.we;

  // Held entries are rewritten with their forwarded operands every cycle so a
  // stalled op keeps producer values after they leave EX/WB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= sel_fwd;
            state  <= ONE;
          end
        end
        ONE: begin
          main_q <= main_fwd;
          if (acc && dq) begin
            main_q <= sel_fwd;
          end else if (acc) begin
            skid_q <= sel_fwd;
            state  <= FULL;
          end else if (dq) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          main_q <= main_fwd;
          skid_q <= sel_fwd;
          if (dq) begin
            main_q <= sel_fwd;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
